// File: rtl/seq_pkg.sv
// Shared types for the multi-cycle instruction sequencer: state encoding and fault codes.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    FAULT  = 3'd7
  } seq_state_t;

  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_ILLEGAL = 2'd1,
    FC_TIMEOUT = 2'd2
  } fault_code_t;

endpackage

// File: rtl/seq_watchdog.sv
// 8-bit wait-state watchdog: counts consecutive cycles of an unanswered wait and
// flags expiry on the LIMIT-th such cycle. The count restarts whenever the wait ends.
module seq_watchdog #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic wait_i,
  input  logic done_i,
  output logic expire_o
);

  localparam logic [7:0] LIMIT_M1 = 8'(LIMIT - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Cycle counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Count while the wait is unanswered; cnt_q holds the number of earlier wait cycles.
  always_comb begin
    cnt_d = 8'd0;
    if (wait_i && !done_i) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = 8'd0;
    end
  end

  assign expire_o = wait_i & ~done_i & (cnt_q == LIMIT_M1);

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle RISC-V instruction sequencer (FETCH/DECODE/EXEC/MEM/WB with retire).
// Optional wait-state watchdog is built when SEQ_WATCHDOG_EN is defined.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             reg_write,
  input  logic             is_fp,
  input  logic             mem_ack,
  input  logic             fp_done,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_is_fetch,
  output logic             ir_load,
  output logic             fp_start,
  output logic             rf_we,
  output logic             pc_en,
  output seq_state_t       state,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] retired
);

  seq_state_t       state_q, state_d;
  fault_code_t      fault_code_q, fault_code_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             ld_q, ld_d, st_q, st_d, rw_q, rw_d, fp_q, fp_d;
  logic             fp_wait_q, fp_wait_d;
  logic             retire_s, exec_exit_s, expire_s, wait_s, done_s;

  // State, decoded flags, fault code and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      fault_code_q <= FC_NONE;
      retired_q    <= '0;
      ld_q         <= 1'b0;
      st_q         <= 1'b0;
      rw_q         <= 1'b0;
      fp_q         <= 1'b0;
      fp_wait_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fault_code_q <= fault_code_d;
      retired_q    <= retired_d;
      ld_q         <= ld_d;
      st_q         <= st_d;
      rw_q         <= rw_d;
      fp_q         <= fp_d;
      fp_wait_q    <= fp_wait_d;
    end
  end

  // FP wait starts the cycle after fp_start; only then is fp_done honoured.
  assign wait_s = (state_q == FETCH) | (state_q == MEM) | ((state_q == EXEC) & fp_q & fp_wait_q);
  assign done_s = (((state_q == FETCH) | (state_q == MEM)) & mem_ack) |
                  ((state_q == EXEC) & fp_q & fp_wait_q & fp_done);

  // Next-state, flag capture and retire decision.
  always_comb begin
    state_d      = state_q;
    fault_code_d = fault_code_q;
    retired_d    = retired_q;
    ld_d         = ld_q;
    st_d         = st_q;
    rw_d         = rw_q;
    fp_d         = fp_q;
    fp_wait_d    = 1'b0;
    retire_s     = 1'b0;
    exec_exit_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
        else     state_d = IDLE;
      end
      FETCH: begin
        if (mem_ack)       state_d = DECODE;
        else if (expire_s) begin
          state_d      = FAULT;
          fault_code_d = FC_TIMEOUT;
        end else           state_d = FETCH;
      end
      DECODE: begin
        ld_d = mem_read;
        st_d = mem_write;
        rw_d = reg_write;
        fp_d = is_fp;
        if (mem_read && mem_write) begin
          state_d      = FAULT;
          fault_code_d = FC_ILLEGAL;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!fp_q)            exec_exit_s = 1'b1;
        else if (!fp_wait_q)  fp_wait_d   = 1'b1;
        else if (fp_done)     exec_exit_s = 1'b1;
        else if (expire_s) begin
          state_d      = FAULT;
          fault_code_d = FC_TIMEOUT;
        end else              fp_wait_d   = 1'b1;
        if (exec_exit_s) begin
          if (ld_q || st_q) state_d  = MEM;
          else if (rw_q)    state_d  = WB;
          else              retire_s = 1'b1;
        end else begin
          exec_exit_s = 1'b0;
        end
      end
      MEM: begin
        // A store never writes back, even with reg_write set.
        if (mem_ack) begin
          if (st_q)              retire_s = 1'b1;
          else if (ld_q || rw_q) state_d  = WB;
          else                   retire_s = 1'b1;
        end else if (expire_s) begin
          state_d      = FAULT;
          fault_code_d = FC_TIMEOUT;
        end else begin
          state_d = MEM;
        end
      end
      WB:      retire_s = 1'b1;
      FAULT:   state_d  = FAULT;
      default: state_d  = FAULT;
    endcase
    if (retire_s) begin
      state_d   = run ? FETCH : IDLE;
      retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      retired_d = retired_q;
    end
  end

`ifdef SEQ_WATCHDOG_EN
  seq_watchdog #(.LIMIT(MEM_TIMEOUT)) u_watchdog (
    .clk_i    (clk),
    .rst_i    (rst),
    .wait_i   (wait_s),
    .done_i   (done_s),
    .expire_o (expire_s)
  );
`else
  logic unused_wdog_s;
  assign expire_s      = 1'b0;
  assign unused_wdog_s = ^{MEM_TIMEOUT, wait_s, done_s};
`endif

  assign mem_req      = (state_q == FETCH) | (state_q == MEM);
  assign mem_is_fetch = (state_q == FETCH);
  assign mem_we       = (state_q == MEM) & st_q;
  assign ir_load      = (state_q == FETCH) & mem_ack;
  assign fp_start     = (state_q == EXEC) & fp_q & ~fp_wait_q;
  assign rf_we        = (state_q == WB);
  assign pc_en        = retire_s;
  assign state        = state_q;
  assign fault        = (state_q == FAULT);
  assign fault_code   = fault_code_q;
  assign retired      = retired_q;

endmodule
